// File: rtl/alu_share_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : alu_share_arbiter (with local helper module alu)           |
// | Description : Shares one ALU between two valid/ready requesters, using   |
// |               round-robin or fixed-priority arbitration. The result is   |
// |               registered into a tagged valid/ready response stage.       |
// |               Per-requester issue counters are kept for perf debug.      |
// | Options     : `define ALU_ARB_ONEHOT_CHK_EN flags any accepted control   |
// |               word that is not one-hot (rsp_err=1, result forced to 0).  |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+

// Single-cycle ALU. The control word is one-hot:
// {add, sub, slt, sltu, and, nor, or, xor, sll, srl, sra, lui}, bit 11 = add.
// Shifts shift src2 by src1[4:0]; lui places src2[15:0] in the upper half.
module alu (
   input  logic [11:0] alu_control,
   input  logic [31:0] alu_src1,
   input  logic [31:0] alu_src2,
   output logic [31:0] alu_result
);

   logic [4:0] shamt;

   assign shamt = alu_src1[4:0];

   // Priority decode from bit 11 downwards; an all-zero word yields 0
   always_comb begin
      alu_result = 32'd0;
      if (alu_control[11])
         alu_result = alu_src1 + alu_src2;
      else if (alu_control[10])
         alu_result = alu_src1 - alu_src2;
      else if (alu_control[9])
         alu_result = {31'd0, ($signed(alu_src1) < $signed(alu_src2))};
      else if (alu_control[8])
         alu_result = {31'd0, (alu_src1 < alu_src2)};
      else if (alu_control[7])
         alu_result = alu_src1 & alu_src2;
      else if (alu_control[6])
         alu_result = ~(alu_src1 | alu_src2);
      else if (alu_control[5])
         alu_result = alu_src1 | alu_src2;
      else if (alu_control[4])
         alu_result = alu_src1 ^ alu_src2;
      else if (alu_control[3])
         alu_result = alu_src2 << shamt;
      else if (alu_control[2])
         alu_result = alu_src2 >> shamt;
      else if (alu_control[1])
         alu_result = 32'($signed(alu_src2) >>> shamt);
      else if (alu_control[0])
         alu_result = {alu_src2[15:0], 16'd0};
   end

endmodule

module alu_share_arbiter #(
   parameter int FIXED_PRIO = 0,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [11:0]      req0_control,
   input  logic [31:0]      req0_src1,
   input  logic [31:0]      req0_src2,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [11:0]      req1_control,
   input  logic [31:0]      req1_src1,
   input  logic [31:0]      req1_src2,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [31:0]      rsp_result,
   output logic             rsp_err,
   output logic [CNT_W-1:0] cnt0,
   output logic [CNT_W-1:0] cnt1
);

   // Response stage and arbitration state
   logic             rsp_valid_q,  rsp_valid_d;
   logic             rsp_id_q,     rsp_id_d;
   logic [31:0]      rsp_result_q, rsp_result_d;
   logic             rsp_err_q,    rsp_err_d;
   logic [CNT_W-1:0] cnt0_q,       cnt0_d;
   logic [CNT_W-1:0] cnt1_q,       cnt1_d;
   logic             last_grant_q, last_grant_d;

   logic        stage_free;
   logic        both_pick1;
   logic        grant0;
   logic        grant1;
   logic        accept0;
   logic        accept1;
   logic        accept;
   logic [11:0] sel_control;
   logic [31:0] sel_src1;
   logic [31:0] sel_src2;
   logic [31:0] alu_out;
   logic [31:0] captured_result;
   logic        ctrl_bad;

   // The stage can take a new result when empty or being drained this cycle
   assign stage_free = ~rsp_valid_q | rsp_ready;

   // Winner of a conflict: fixed priority always picks requester 0,
   // round-robin picks whichever requester did not win last time
   generate
      if (FIXED_PRIO != 0) begin : g_fixed_prio
         assign both_pick1 = 1'b0;
      end else begin : g_round_robin
         assign both_pick1 = ~last_grant_q;
      end
   endgenerate

   // Combinational grant; never grants while the stage is blocked
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (stage_free) begin
         if (req0_valid && req1_valid) begin
            grant0 = ~both_pick1;
            grant1 = both_pick1;
         end else begin
            grant0 = req0_valid;
            grant1 = req1_valid;
         end
      end
   end

   assign req0_ready = stage_free & grant0;
   assign req1_ready = stage_free & grant1;
   assign accept0    = req0_valid & req0_ready;
   assign accept1    = req1_valid & req1_ready;
   assign accept     = accept0 | accept1;

   // Operand steering into the single shared ALU
   assign sel_control = grant1 ? req1_control : req0_control;
   assign sel_src1    = grant1 ? req1_src1    : req0_src1;
   assign sel_src2    = grant1 ? req1_src2    : req0_src2;

   alu u_alu (
      .alu_control (sel_control),
      .alu_src1    (sel_src1),
      .alu_src2    (sel_src2),
      .alu_result  (alu_out)
   );

`ifdef ALU_ARB_ONEHOT_CHK_EN
   // Not one-hot: zero, or clearing the lowest set bit leaves something set
   assign ctrl_bad        = (sel_control == 12'd0) |
                            ((sel_control & (sel_control - 12'd1)) != 12'd0);
   assign captured_result = ctrl_bad ? 32'd0 : alu_out;
`else
   assign ctrl_bad        = 1'b0;
   assign captured_result = alu_out;
`endif

   // Next-state: load on accept (also covers same-cycle drain + reload),
   // otherwise drop valid when the consumer takes the response
   always_comb begin
      rsp_valid_d  = rsp_valid_q;
      rsp_id_d     = rsp_id_q;
      rsp_result_d = rsp_result_q;
      rsp_err_d    = rsp_err_q;
      last_grant_d = last_grant_q;
      cnt0_d       = cnt0_q;
      cnt1_d       = cnt1_q;
      if (accept) begin
         rsp_valid_d  = 1'b1;
         rsp_id_d     = accept1;
         rsp_result_d = captured_result;
         rsp_err_d    = ctrl_bad;
         last_grant_d = accept1;
      end else if (rsp_ready) begin
         rsp_valid_d  = 1'b0;
      end
      if (accept0) begin
         cnt0_d = cnt0_q + CNT_W'(1);
      end
      if (accept1) begin
         cnt1_d = cnt1_q + CNT_W'(1);
      end
   end

   // State registers; last_grant resets to 1 so requester 0 wins first
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= 1'b0;
         rsp_result_q <= 32'd0;
         rsp_err_q    <= 1'b0;
         last_grant_q <= 1'b1;
         cnt0_q       <= '0;
         cnt1_q       <= '0;
      end else begin
         rsp_valid_q  <= rsp_valid_d;
         rsp_id_q     <= rsp_id_d;
         rsp_result_q <= rsp_result_d;
         rsp_err_q    <= rsp_err_d;
         last_grant_q <= last_grant_d;
         cnt0_q       <= cnt0_d;
         cnt1_q       <= cnt1_d;
      end
   end

   assign rsp_valid  = rsp_valid_q;
   assign rsp_id     = rsp_id_q;
   assign rsp_result = rsp_result_q;
   assign rsp_err    = rsp_err_q;
   assign cnt0       = cnt0_q;
   assign cnt1       = cnt1_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_alu_share_arbiter                                       |
// | Description : Two arbiter instances (round-robin CNT_W=3, fixed-priority |
// |               CNT_W=2) share one stimulus stream; each is compared       |
// |               against its own transaction-level reference model.         |
// | Options     : honours `define ALU_ARB_ONEHOT_CHK_EN                      |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_alu_share_arbiter;
   localparam int N = 2;

   typedef struct {
      bit          v;
      logic [11:0] c;
      logic [31:0] a;
      logic [31:0] b;
   } req_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        resetn;
   logic        r0v, r1v, rsp_rdy;
   logic [11:0] r0c, r1c;
   logic [31:0] r0a, r0b, r1a, r1b;

   logic [N-1:0]       rdy0, rdy1, rv, rid, rerr;
   logic [N-1:0][31:0] rres;
   logic [N-1:0][15:0] cn0, cn1;

   for (genvar g = 0; g < N; g++) begin : g_dut
      localparam int FP = (g == 0) ? 0 : 1;
      localparam int CW = (g == 0) ? 3 : 2;
      logic [CW-1:0] c0w, c1w;
      alu_share_arbiter #(.FIXED_PRIO(FP), .CNT_W(CW)) u_dut (
         .clk          (clk),
         .resetn       (resetn),
         .req0_valid   (r0v),
         .req0_ready   (rdy0[g]),
         .req0_control (r0c),
         .req0_src1    (r0a),
         .req0_src2    (r0b),
         .req1_valid   (r1v),
         .req1_ready   (rdy1[g]),
         .req1_control (r1c),
         .req1_src1    (r1a),
         .req1_src2    (r1b),
         .rsp_valid    (rv[g]),
         .rsp_ready    (rsp_rdy),
         .rsp_id       (rid[g]),
         .rsp_result   (rres[g]),
         .rsp_err      (rerr[g]),
         .cnt0         (c0w),
         .cnt1         (c1w)
      );
      assign cn0[g] = {{(16-CW){1'b0}}, c0w};
      assign cn1[g] = {{(16-CW){1'b0}}, c1w};
   end

   int n_chk = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h expected=%h", tag, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic int fp_of(input int i);
      return (i == 0) ? 0 : 1;
   endfunction

   function automatic int cw_of(input int i);
      return (i == 0) ? 3 : 2;
   endfunction

   function automatic logic [31:0] alu_ref(input logic [11:0] op, input logic [31:0] a, input logic [31:0] b);
      case (op)
         12'h800: return a + b;
         12'h400: return a - b;
         12'h200: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         12'h100: return (a < b) ? 32'd1 : 32'd0;
         12'h080: return a & b;
         12'h040: return ~(a | b);
         12'h020: return a | b;
         12'h010: return a ^ b;
         12'h008: return b << a[4:0];
         12'h004: return b >> a[4:0];
         12'h002: return 32'($signed(b) >>> a[4:0]);
         12'h001: return {b[15:0], 16'h0000};
         default: return 32'd0;
      endcase
   endfunction

   bit          m_v[N], m_id[N], m_err[N], m_last[N];
   logic [31:0] m_res[N];
   int          m_cnt0[N], m_cnt1[N];

   function automatic void m_reset(input int i);
      m_v[i] = 0; m_id[i] = 0; m_err[i] = 0; m_last[i] = 1;
      m_res[i] = 32'd0; m_cnt0[i] = 0; m_cnt1[i] = 0;
   endfunction

   function automatic void m_capture(input int i, input req_t q, input bit id);
      bit bad;
`ifdef ALU_ARB_ONEHOT_CHK_EN
      bad = ($countones(q.c) != 1);
`else
      bad = 0;
`endif
      m_v[i]   = 1;
      m_id[i]  = id;
      m_err[i] = bad;
      m_res[i] = bad ? 32'd0 : alu_ref(q.c, q.a, q.b);
      m_last[i] = id;
      if (id) m_cnt1[i] = (m_cnt1[i] + 1) % (1 << cw_of(i));
      else    m_cnt0[i] = (m_cnt0[i] + 1) % (1 << cw_of(i));
   endfunction

   function automatic req_t mk(input bit v, input logic [11:0] c, input logic [31:0] a, input logic [31:0] b);
      req_t q;
      q.v = v; q.c = c; q.a = a; q.b = b;
      return q;
   endfunction

   function automatic logic [11:0] rand_op();
      int k;
      logic [11:0] one;
      k = $urandom_range(0, 13);
      one = 12'h001;
      if (k < 12) return one << k;
`ifdef ALU_ARB_ONEHOT_CHK_EN
      if (k == 12) return 12'($urandom) | 12'h003;
`endif
      return 12'h000;
   endfunction

   // One clock: drive at negedge, compare all outputs, advance model at posedge
   task automatic step(input req_t q0, input req_t q1, input bit rr);
      bit e0[N], e1[N];
      bit free;
      @(negedge clk);
      r0v = q0.v; r0c = q0.c; r0a = q0.a; r0b = q0.b;
      r1v = q1.v; r1c = q1.c; r1a = q1.a; r1b = q1.b;
      rsp_rdy = rr;
      #1;
      for (int i = 0; i < N; i++) begin
         free  = !resetn ? 1'b0 : (!m_v[i] || rr);
         e0[i] = free && q0.v && (!q1.v || fp_of(i) != 0 || m_last[i]);
         e1[i] = free && q1.v && !e0[i];
         if (resetn) begin
            check($sformatf("i%0d.req0_ready", i), 32'(rdy0[i]), 32'(e0[i]));
            check($sformatf("i%0d.req1_ready", i), 32'(rdy1[i]), 32'(e1[i]));
         end
         check($sformatf("i%0d.rsp_valid", i), 32'(rv[i]), 32'(m_v[i]));
         check($sformatf("i%0d.rsp_id", i), 32'(rid[i]), 32'(m_id[i]));
         check($sformatf("i%0d.rsp_result", i), rres[i], m_res[i]);
         check($sformatf("i%0d.rsp_err", i), 32'(rerr[i]), 32'(m_err[i]));
         check($sformatf("i%0d.cnt0", i), 32'(cn0[i]), 32'(m_cnt0[i]));
         check($sformatf("i%0d.cnt1", i), 32'(cn1[i]), 32'(m_cnt1[i]));
      end
      @(posedge clk);
      for (int i = 0; i < N; i++) begin
         if (!resetn)                m_reset(i);
         else if (e0[i] || e1[i])    m_capture(i, e1[i] ? q1 : q0, e1[i]);
         else if (rr)                m_v[i] = 0;
      end
      #2;
   endtask

   req_t idle;

   initial begin
      idle   = mk(0, 12'h000, 32'd0, 32'd0);
      resetn = 1'b0;
      r0v = 0; r1v = 0; rsp_rdy = 0;
      r0c = '0; r1c = '0; r0a = '0; r0b = '0; r1a = '0; r1b = '0;
      for (int i = 0; i < N; i++) m_reset(i);
      step(idle, idle, 1);
      step(idle, idle, 1);
      resetn = 1'b1;
      step(idle, idle, 1);

      // Single add from requester 0
      step(mk(1, 12'h800, 32'd5, 32'd7), idle, 1);
      for (int i = 0; i < N; i++) check($sformatf("i%0d.add_result", i), rres[i], 32'd12);

      // slt from requester 1, then 3 cycles of backpressure with both valid
      step(idle, mk(1, 12'h200, 32'hFFFF_FFFF, 32'd1), 1);
      for (int k = 0; k < 3; k++) begin
         step(mk(1, 12'h400, 32'd10, 32'd3), mk(1, 12'h008, 32'd4, 32'd1), 0);
         for (int i = 0; i < N; i++) check($sformatf("i%0d.slt_held", i), rres[i], 32'd1);
      end

      // Release: both valid continuously, sub and sll
      for (int k = 0; k < 4; k++) begin
         step(mk(1, 12'h400, 32'd10, 32'd3), mk(1, 12'h008, 32'd4, 32'd1), 1);
         check("i0.rr_id", 32'(rid[0]), 32'(k % 2));
         check("i0.rr_result", rres[0], (k % 2) ? 32'd16 : 32'd7);
         check("i1.fp_id", 32'(rid[1]), 32'd0);
      end

      // Five accepts from requester 0 (counter wrap on both instances)
      for (int k = 0; k < 5; k++) step(mk(1, 12'h020, 32'(k), 32'h100), idle, 1);

      // Zero / multi-hot control words, then lui
      step(mk(1, 12'h000, 32'd9, 32'd9), idle, 1);
`ifdef ALU_ARB_ONEHOT_CHK_EN
      check("i0.zero_err", 32'(rerr[0]), 32'd1);
      step(mk(1, 12'h880, 32'd9, 32'd9), idle, 1);
      check("i0.multi_err", 32'(rerr[0]), 32'd1);
`else
      check("i0.zero_err", 32'(rerr[0]), 32'd0);
`endif
      check("i0.bad_result", rres[0], 32'd0);
      step(mk(1, 12'h001, 32'd0, 32'h0000_1234), idle, 1);
      check("i0.lui_result", rres[0], 32'h1234_0000);
      check("i0.lui_err", 32'(rerr[0]), 32'd0);

      // Randomized traffic
      for (int k = 0; k < 400; k++) begin
         step(mk($urandom_range(0, 3) != 0, rand_op(), $urandom(), $urandom()),
              mk($urandom_range(0, 3) != 0, rand_op(), $urandom(), $urandom()),
              $urandom_range(0, 3) != 0);
      end

      // Reset while a response is held under backpressure
      step(mk(1, 12'h800, 32'd1, 32'd2), idle, 1);
      step(idle, idle, 0);
      @(negedge clk);
      #2;
      resetn = 1'b0;
      #1;
      for (int i = 0; i < N; i++) begin
         check($sformatf("i%0d.rst_valid", i), 32'(rv[i]), 32'd0);
         check($sformatf("i%0d.rst_cnt0", i), 32'(cn0[i]), 32'd0);
         check($sformatf("i%0d.rst_cnt1", i), 32'(cn1[i]), 32'd0);
         m_reset(i);
      end
      @(posedge clk);
      #2;
      resetn = 1'b1;
      step(mk(1, 12'h800, 32'd3, 32'd4), mk(1, 12'h800, 32'd5, 32'd6), 1);
      for (int i = 0; i < N; i++) check($sformatf("i%0d.post_rst_id", i), 32'(rid[i]), 32'd0);
      step(mk(1, 12'h800, 32'd3, 32'd4), mk(1, 12'h800, 32'd5, 32'd6), 1);
      step(idle, idle, 1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
